shared_divider: RTL

- Iterative unsigned radix-2 restoring divider, shared by the two speed stages: client 0 is current speed, client 1 is average speed.
- Sits directly downstream of the average-speed stage. It consumes that stage's dividend/divisor and returns quotient, busy and a ready strobe.
- Two request ports with round-robin arbitration, per-client operand capture, and a divide-by-zero flag.

---
 rtl/div_pkg.sv | 14 +
 rtl/div_core.sv | 94 +++++++++
 rtl/shared_divider.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and defaults for the speed-stage divider.
package div_pkg;
  localparam int unsigned DIV_WIDTH = 16;
  localparam int unsigned DIV_CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam logic CLI_CUR = 1'b0;
  localparam logic CLI_AVG = 1'b1;
endpackage

// File: rtl/div_core.sv
// Radix-2 restoring division datapath: remainder/quotient shift registers,
// trial subtractor and iteration counter. Sequencing is owned by the caller.
module div_core
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH,
  parameter int unsigned CNT_W = DIV_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             last_o,
  output logic             zero_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fin_q, fin_d;
  logic             zero_q, zero_d;
  logic [WIDTH:0]   shifted_c;
  logic [WIDTH:0]   diff_c;

  // Dividend bits leave quo_q at the MSB while quotient bits enter at the LSB.
  always_comb begin
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    fin_d     = fin_q;
    zero_d    = zero_q;
    shifted_c = {rem_q, quo_q[WIDTH-1]};
    diff_c    = shifted_c - {1'b0, dvs_q};
    if (load_i) begin
      dvs_d  = divisor_i;
      fin_d  = 1'b0;
      zero_d = (divisor_i == '0);
      if (divisor_i == '0) begin
        rem_d = dividend_i;
        quo_d = '1;
        cnt_d = '0;
      end else begin
        rem_d = '0;
        quo_d = dividend_i;
        cnt_d = CNT_W'(WIDTH - 1);
      end
    end else if (step_i && !fin_q) begin
      if (!zero_q) begin
        if (!diff_c[WIDTH]) begin
          rem_d = diff_c[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted_c[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
      end
      if (cnt_q == '0) begin
        fin_d = 1'b1;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      fin_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      fin_q  <= fin_d;
      zero_q <= zero_d;
    end
  end

  assign last_o      = fin_q;
  assign zero_o      = zero_q;
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule

// File: rtl/shared_divider.sv
// Divider shared by the current-speed (client 0) and average-speed (client 1)
// stages: per-client pending capture, round-robin arbiter and sequencing FSM.
module shared_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH,
  parameter int unsigned CNT_W = DIV_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] dividend0,
  input  logic [WIDTH-1:0] divisor0,
  input  logic             req1,
  input  logic [WIDTH-1:0] dividend1,
  input  logic [WIDTH-1:0] divisor1,
  output logic             busy,
  output logic             ready0,
  output logic             ready1,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  div_state_e       state_q, state_d;
  logic             pend0_q, pend1_q;
  logic [WIDTH-1:0] pend_dvd0_q, pend_dvs0_q, pend_dvd1_q, pend_dvs1_q;
  logic             last_grant_q;
  logic             busy_q, ready0_q, ready1_q, div_zero_q;
  logic [WIDTH-1:0] quotient_q, remainder_q;

  logic             elig0_c, elig1_c;
  logic             load_c, step_c, gnt_cli_c;
  logic [WIDTH-1:0] op_dvd_c, op_dvs_c;

  logic             core_last, core_zero;
  logic [WIDTH-1:0] core_quo, core_rem;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pend0_q || pend1_q || req0 || req1) state_d = CALC;
      CALC:    if (core_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant, operand select and datapath controls; live port beats pending copy.
  always_comb begin
    elig0_c   = pend0_q || req0;
    elig1_c   = pend1_q || req1;
    load_c    = (state_q == IDLE) && (elig0_c || elig1_c);
    step_c    = (state_q == CALC);
    gnt_cli_c = (elig0_c && elig1_c) ? ~last_grant_q : elig1_c;
    op_dvd_c  = '0;
    op_dvs_c  = '0;
    if (gnt_cli_c == CLI_CUR) begin
      op_dvd_c = req0 ? dividend0 : pend_dvd0_q;
      op_dvs_c = req0 ? divisor0  : pend_dvs0_q;
    end else begin
      op_dvd_c = req1 ? dividend1 : pend_dvd1_q;
      op_dvs_c = req1 ? divisor1  : pend_dvs1_q;
    end
  end

  // Pending capture; a grant consumes the request so it is not re-armed.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend0_q     <= 1'b0;
      pend1_q     <= 1'b0;
      pend_dvd0_q <= '0;
      pend_dvs0_q <= '0;
      pend_dvd1_q <= '0;
      pend_dvs1_q <= '0;
    end else begin
      if (load_c && gnt_cli_c == CLI_CUR) begin
        pend0_q <= 1'b0;
      end else if (req0) begin
        pend0_q     <= 1'b1;
        pend_dvd0_q <= dividend0;
        pend_dvs0_q <= divisor0;
      end
      if (load_c && gnt_cli_c == CLI_AVG) begin
        pend1_q <= 1'b0;
      end else if (req1) begin
        pend1_q     <= 1'b1;
        pend_dvd1_q <= dividend1;
        pend_dvs1_q <= divisor1;
      end
    end
  end

  // Registered outputs; last_grant_q also names the client in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= CLI_AVG;
      busy_q       <= 1'b0;
      ready0_q     <= 1'b0;
      ready1_q     <= 1'b0;
      quotient_q   <= '0;
      remainder_q  <= '0;
      div_zero_q   <= 1'b0;
    end else begin
      busy_q   <= (state_d != IDLE);
      ready0_q <= (state_d == DONE) && (last_grant_q == CLI_CUR);
      ready1_q <= (state_d == DONE) && (last_grant_q == CLI_AVG);
      if (load_c) last_grant_q <= gnt_cli_c;
      if (state_q == CALC && state_d == DONE) begin
        quotient_q  <= core_quo;
        remainder_q <= core_rem;
        div_zero_q  <= core_zero;
      end
    end
  end

  div_core #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_core (
    .clk         (clk),
    .rst         (rst),
    .load_i      (load_c),
    .step_i      (step_c),
    .dividend_i  (op_dvd_c),
    .divisor_i   (op_dvs_c),
    .last_o      (core_last),
    .zero_o      (core_zero),
    .quotient_o  (core_quo),
    .remainder_o (core_rem)
  );

  assign busy      = busy_q;
  assign ready0    = ready0_q;
  assign ready1    = ready1_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div_zero  = div_zero_q;

endmodule
